// File: rtl/forwarding_scoreboard_pkg.sv
// rtl/forwarding_scoreboard_pkg.sv - shared defaults and types for the forwarding scoreboard
// Purpose: default widths for register address, result data and latency
//          counters, plus the default-width view of one result-bus tag.
// Ports:   none (package spu_fwd_pkg).
package spu_fwd_pkg;

  localparam int DEF_ADDR_W = 7;
  localparam int DEF_DATA_W = 128;
  localparam int DEF_LAT_W  = 3;

  // Control half of one result bus at default widths (data travels separately).
  typedef struct packed {
    logic                  we;
    logic [DEF_ADDR_W-1:0] rt;
    logic                  ready;
  } st_tag_t;

endpackage

// File: rtl/forwarding_scoreboard_if.sv
// rtl/forwarding_scoreboard_if.sv - ID/forwarding bus between pipeline and scoreboard
// Purpose: bundles operand reads, issue request, per-stage result buses and
//          the forward/stall answers.
// Ports:   master = pipeline side (drives operands, issue, stage buses);
//          slave  = scoreboard side (drives fwd_data, fwd_sel, stall, issue_fire).
interface forwarding_scoreboard_if
  import spu_fwd_pkg::*;
#(
  parameter int NUM_OPS    = 3,
  parameter int NUM_STAGES = 5,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int LAT_W      = DEF_LAT_W
);
  logic [NUM_OPS-1:0]                 op_used;
  logic [NUM_OPS-1:0][ADDR_W-1:0]     op_reg;
  logic                               issue_valid;
  logic                               issue_we;
  logic [ADDR_W-1:0]                  issue_rt;
  logic [LAT_W-1:0]                   issue_lat;
  logic [NUM_STAGES-1:0]              st_we;
  logic [NUM_STAGES-1:0][ADDR_W-1:0]  st_rt;
  logic [NUM_STAGES-1:0]              st_ready;
  logic [NUM_STAGES-1:0][DATA_W-1:0]  st_result;
  logic [NUM_OPS-1:0][DATA_W-1:0]     fwd_data;
  logic [NUM_OPS-1:0]                 fwd_sel;
  logic                               stall;
  logic                               issue_fire;

  modport master (
    output op_used, op_reg, issue_valid, issue_we, issue_rt, issue_lat,
    output st_we, st_rt, st_ready, st_result,
    input  fwd_data, fwd_sel, stall, issue_fire
  );

  modport slave (
    input  op_used, op_reg, issue_valid, issue_we, issue_rt, issue_lat,
    input  st_we, st_rt, st_ready, st_result,
    output fwd_data, fwd_sel, stall, issue_fire
  );
endinterface

// File: rtl/fwd_operand_mux.sv
// rtl/fwd_operand_mux.sv - priority match, forward select and hazard for one operand
// Purpose: finds the youngest stage writing this operand's register; forwards
//          it when ready, flags a hazard when it is not or the register is pending.
// Ports:   used/reg_addr/pending (operand), st_we/st_rt/st_ready/st_result
//          (stage buses), sel/data/hazard (answers).
module fwd_operand_mux #(
  parameter int NUM_STAGES = 5,
  parameter int DATA_W     = 128,
  parameter int ADDR_W     = 7
) (
  input  logic                              used,
  input  logic [ADDR_W-1:0]                 reg_addr,
  input  logic                              pending,
  input  logic [NUM_STAGES-1:0]             st_we,
  input  logic [NUM_STAGES-1:0][ADDR_W-1:0] st_rt,
  input  logic [NUM_STAGES-1:0]             st_ready,
  input  logic [NUM_STAGES-1:0][DATA_W-1:0] st_result,
  output logic                              sel,
  output logic [DATA_W-1:0]                 data,
  output logic                              hazard
);
  logic              match;
  logic              hit_ready;
  logic [DATA_W-1:0] hit_result;

  // Scan oldest to youngest so the youngest matching stage wins. Its ready
  // bit alone decides: an older ready copy is stale and must not be used.
  always_comb begin
    match      = 1'b0;
    hit_ready  = 1'b0;
    hit_result = '0;
    for (int s = NUM_STAGES - 1; s >= 0; s--) begin
      if (st_we[s] && st_rt[s] == reg_addr) begin
        match      = 1'b1;
        hit_ready  = st_ready[s];
        hit_result = st_result[s];
      end
    end
  end

  assign sel    = used & match & hit_ready;
  assign data   = sel ? hit_result : '0;
  assign hazard = used & (pending | (match & ~hit_ready));
endmodule

// File: rtl/forwarding_scoreboard.sv
// rtl/forwarding_scoreboard.sv - per-register latency scoreboard with result forwarding
// Purpose: tracks cycles until each register's result is forwardable, stalls
//          ID on hazards and selects forwarded operands from the stage buses.
// Ports:   clk, reset (async, active high), flush (clears pending entries),
//          bus (forwarding_scoreboard_if.slave).
//          With FWD_STATS_EN defined: stall_cycles (32b wrapping count of
//          stalled cycles), max_stall_run (16b saturating longest stall run).
module forwarding_scoreboard
  import spu_fwd_pkg::*;
#(
  parameter int NUM_OPS    = 3,
  parameter int NUM_STAGES = 5,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int LAT_W      = DEF_LAT_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  forwarding_scoreboard_if.slave bus
`ifdef FWD_STATS_EN
  ,
  output logic [31:0]            stall_cycles,
  output logic [15:0]            max_stall_run
`endif
);
  logic [LAT_W-1:0]               cnt [2**ADDR_W];
  logic [NUM_OPS-1:0]             hazard;
  logic [NUM_OPS-1:0]             sel_w;
  logic [NUM_OPS-1:0][DATA_W-1:0] data_w;
  logic                           load;

  // Stall and forwarding depend only on operands, counters and stage buses,
  // never on issue_*, so issue_fire can safely be derived from stall.
  assign bus.stall      = |hazard;
  assign bus.fwd_sel    = sel_w;
  assign bus.fwd_data   = data_w;
  assign bus.issue_fire = bus.issue_valid & ~bus.stall & ~flush & ~reset;
  assign load           = bus.issue_fire & bus.issue_we;

  for (genvar i = 0; i < NUM_OPS; i++) begin : g_op
    logic pending;
    assign pending = (cnt[bus.op_reg[i]] != '0);

    fwd_operand_mux #(
      .NUM_STAGES (NUM_STAGES),
      .DATA_W     (DATA_W),
      .ADDR_W     (ADDR_W)
    ) u_mux (
      .used      (bus.op_used[i]),
      .reg_addr  (bus.op_reg[i]),
      .pending   (pending),
      .st_we     (bus.st_we),
      .st_rt     (bus.st_rt),
      .st_ready  (bus.st_ready),
      .st_result (bus.st_result),
      .sel       (sel_w[i]),
      .data      (data_w[i]),
      .hazard    (hazard[i])
    );
  end

  // A fresh issue overrides the decrement of the same register's counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < 2**ADDR_W; r++) cnt[r] <= '0;
    end else if (flush) begin
      for (int r = 0; r < 2**ADDR_W; r++) cnt[r] <= '0;
    end else begin
      for (int r = 0; r < 2**ADDR_W; r++) begin
        if (load && bus.issue_rt == ADDR_W'(r)) cnt[r] <= bus.issue_lat;
        else if (cnt[r] != '0)                  cnt[r] <= cnt[r] - LAT_W'(1);
      end
    end
  end

`ifdef FWD_STATS_EN
  logic [15:0] run;
  logic [15:0] run_inc;

  assign run_inc = (run == 16'hFFFF) ? run : run + 16'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles  <= '0;
      max_stall_run <= '0;
      run           <= '0;
    end else if (bus.stall) begin
      stall_cycles <= stall_cycles + 32'd1;
      run          <= run_inc;
      if (run_inc > max_stall_run) max_stall_run <= run_inc;
    end else begin
      run <= '0;
    end
  end
`endif
endmodule

// File: tb/tb_forwarding_scoreboard.sv
// tb/tb_forwarding_scoreboard.sv - directed vector bench for forwarding_scoreboard
module tb_forwarding_scoreboard;
  import spu_fwd_pkg::*;

  localparam int NO = 3;
  localparam int NS = 5;
  localparam int DW = 128;
  localparam int AW = 7;
  localparam int LW = 3;

  logic clk = 1'b0;
  logic reset;
  logic flush;
`ifdef FWD_STATS_EN
  logic [31:0] stall_cycles;
  logic [15:0] max_stall_run;
`endif

  int nvec = 0;
  int nbad = 0;

  forwarding_scoreboard_if #(.NUM_OPS(NO), .NUM_STAGES(NS), .DATA_W(DW), .ADDR_W(AW), .LAT_W(LW)) bus ();

  forwarding_scoreboard #(.NUM_OPS(NO), .NUM_STAGES(NS), .DATA_W(DW), .ADDR_W(AW), .LAT_W(LW)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
`ifdef FWD_STATS_EN
    ,
    .stall_cycles  (stall_cycles),
    .max_stall_run (max_stall_run)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NO-1:0] used;
    logic [AW-1:0] reg_a [NO];
    st_tag_t       tag [NS];
    int            src [NO];
    logic          stall;
  } vec_t;

  logic [DW-1:0] sval [NS];
  vec_t          vt [9];

  function automatic vec_t blank();
    vec_t v;
    v.used  = '0;
    v.stall = 1'b0;
    for (int i = 0; i < NO; i++) begin v.reg_a[i] = '0; v.src[i] = -1; end
    for (int s = 0; s < NS; s++) v.tag[s] = '{we: 1'b0, rt: 7'd0, ready: 1'b0};
    return v;
  endfunction

  function automatic st_tag_t tg(input logic [AW-1:0] rt, input logic rdy);
    return '{we: 1'b1, rt: rt, ready: rdy};
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clr();
    bus.op_used     = '0;
    bus.op_reg      = '0;
    bus.issue_valid = 1'b0;
    bus.issue_we    = 1'b0;
    bus.issue_rt    = '0;
    bus.issue_lat   = '0;
    bus.st_we       = '0;
    bus.st_rt       = '0;
    bus.st_ready    = '0;
    for (int s = 0; s < NS; s++) bus.st_result[s] = sval[s];
    flush           = 1'b0;
  endtask

  task automatic issue(input logic [AW-1:0] rt, input logic [LW-1:0] lat);
    bus.issue_valid = 1'b1;
    bus.issue_we    = 1'b1;
    bus.issue_rt    = rt;
    bus.issue_lat   = lat;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DW-1:0] exp_d;

    sval[0] = {16{8'h11}};
    sval[1] = {16{8'hAA}};
    sval[2] = {16{8'h33}};
    sval[3] = {16{8'h44}};
    sval[4] = {16{8'h55}};

    // nothing used
    vt[0] = blank();
    vt[0].tag[1] = tg(7'd9, 1'b1);
    // single ready match on stage 1
    vt[1] = blank();
    vt[1].used = 3'b010; vt[1].reg_a[1] = 7'd9;
    vt[1].tag[1] = tg(7'd9, 1'b1); vt[1].src[1] = 1;
    // youngest match not ready, older ready: stall, no forward
    vt[2] = blank();
    vt[2].used = 3'b001; vt[2].reg_a[0] = 7'd9;
    vt[2].tag[0] = tg(7'd9, 1'b0); vt[2].tag[2] = tg(7'd9, 1'b1); vt[2].stall = 1'b1;
    // both ready: youngest wins
    vt[3] = blank();
    vt[3].used = 3'b001; vt[3].reg_a[0] = 7'd9;
    vt[3].tag[0] = tg(7'd9, 1'b1); vt[3].tag[2] = tg(7'd9, 1'b1); vt[3].src[0] = 0;
    // two operands share a stage, third misses
    vt[4] = blank();
    vt[4].used = 3'b111; vt[4].reg_a[0] = 7'd4; vt[4].reg_a[1] = 7'd9; vt[4].reg_a[2] = 7'd4;
    vt[4].tag[3] = tg(7'd4, 1'b1); vt[4].src[0] = 3; vt[4].src[2] = 3;
    // match but operand unused
    vt[5] = blank();
    vt[5].used = 3'b000; vt[5].reg_a[0] = 7'd4;
    vt[5].tag[3] = tg(7'd4, 1'b1);
    // independent operands: one hazard, one forward
    vt[6] = blank();
    vt[6].used = 3'b011; vt[6].reg_a[0] = 7'd9; vt[6].reg_a[1] = 7'd4;
    vt[6].tag[1] = tg(7'd9, 1'b0); vt[6].tag[4] = tg(7'd4, 1'b1);
    vt[6].src[1] = 4; vt[6].stall = 1'b1;
    // address matches but write enable low
    vt[7] = blank();
    vt[7].used = 3'b001; vt[7].reg_a[0] = 7'd9;
    vt[7].tag[0] = '{we: 1'b0, rt: 7'd9, ready: 1'b1};
    // top register address from the oldest stage
    vt[8] = blank();
    vt[8].used = 3'b100; vt[8].reg_a[2] = 7'd127;
    vt[8].tag[4] = tg(7'd127, 1'b1); vt[8].src[2] = 4;

    // reset state
    clr();
    reset = 1'b1;
    bus.issue_valid = 1'b1;
    #12;
    chk("reset_stall", DW'(bus.stall), DW'(0));
    chk("reset_fire", DW'(bus.issue_fire), DW'(0));
    chk("reset_sel", DW'(bus.fwd_sel), DW'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    #1;

    // combinational vectors (all counters zero, issue without write)
    for (int k = 0; k < 9; k++) begin
      bus.op_used     = vt[k].used;
      bus.issue_valid = 1'b1;
      bus.issue_we    = 1'b0;
      for (int i = 0; i < NO; i++) bus.op_reg[i] = vt[k].reg_a[i];
      for (int s = 0; s < NS; s++) begin
        bus.st_we[s]    = vt[k].tag[s].we;
        bus.st_rt[s]    = vt[k].tag[s].rt;
        bus.st_ready[s] = vt[k].tag[s].ready;
      end
      #1;
      for (int i = 0; i < NO; i++) begin
        exp_d = (vt[k].src[i] < 0) ? '0 : sval[vt[k].src[i]];
        chk($sformatf("v%0d_sel%0d", k, i), DW'(bus.fwd_sel[i]), DW'(vt[k].src[i] >= 0));
        chk($sformatf("v%0d_data%0d", k, i), bus.fwd_data[i], exp_d);
      end
      chk($sformatf("v%0d_stall", k), DW'(bus.stall), DW'(vt[k].stall));
      chk($sformatf("v%0d_fire", k), DW'(bus.issue_fire), DW'(!vt[k].stall));
      #1;
    end

    // latency stall: rt=5 lat=2
    clr();
    next();
    issue(7'd5, 3'd2);
    #1 chk("a_fire", DW'(bus.issue_fire), DW'(1));
    next();
    bus.issue_we = 1'b0;
    bus.op_used[0] = 1'b1; bus.op_reg[0] = 7'd5;
    #1 chk("a_stall_c1", DW'(bus.stall), DW'(1));
    chk("a_fire_blocked", DW'(bus.issue_fire), DW'(0));
    next();
    chk("a_stall_c2", DW'(bus.stall), DW'(1));
    next();
    chk("a_stall_c3", DW'(bus.stall), DW'(0));
    chk("a_fire_released", DW'(bus.issue_fire), DW'(1));

    // issue load beats decrement on the same register
    clr();
    next();
    issue(7'd7, 3'd1);
    next();
    issue(7'd7, 3'd1);
    #1 chk("b_fire", DW'(bus.issue_fire), DW'(1));
    next();
    clr();
    bus.op_used[0] = 1'b1; bus.op_reg[0] = 7'd7;
    #1 chk("b_cnt7_is_1", DW'(bus.stall), DW'(1));
    next();
    chk("b_cnt7_drained", DW'(bus.stall), DW'(0));

    // flush clears pending counters and blocks issue
    clr();
    next();
    issue(7'd12, 3'd3);
    next();
    flush = 1'b1;
    issue(7'd12, 3'd3);
    #1 chk("c_fire_flush", DW'(bus.issue_fire), DW'(0));
    next();
    clr();
    bus.op_used[0] = 1'b1; bus.op_reg[0] = 7'd12;
    #1 chk("c_no_stall", DW'(bus.stall), DW'(0));

    // reset asserted mid-stall
    clr();
    next();
    issue(7'd20, 3'd3);
    next();
    bus.issue_we = 1'b0;
    bus.op_used[0] = 1'b1; bus.op_reg[0] = 7'd20;
    #1 chk("d_stall_c1", DW'(bus.stall), DW'(1));
    next();
    chk("d_stall_c2", DW'(bus.stall), DW'(1));
    #2 reset = 1'b1;
    #1;
    chk("d_reset_stall", DW'(bus.stall), DW'(0));
    chk("d_reset_fire", DW'(bus.issue_fire), DW'(0));
`ifdef FWD_STATS_EN
    chk("d_stall_cycles", DW'(stall_cycles), DW'(0));
    chk("d_max_run", DW'(max_stall_run), DW'(0));
`endif
    next();
    reset = 1'b0;
    clr();
    #1 chk("d_after_reset_stall", DW'(bus.stall), DW'(0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
